// File: rtl/icache_if.sv
// icache_if: fetch-side and memory-side handshake bundle for the icache.
//
// Fetch unit -> cache:  IFIC_en, IFIC_addr, RoB_clear
// Cache -> fetch unit:  ICIF_en, ICIF_inst
// Cache -> memory ctrl: ICMC_en, ICMC_addr
// Memory ctrl -> cache: MCIC_en, MCIC_block
//
// modport slave  : the cache's view (serves fetches, drives block reads).
// modport master : the surrounding fetch unit / memory controller view.
interface icache_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 1
);
    logic                          IFIC_en;
    logic [ADDR_WIDTH-1:0]         IFIC_addr;
    logic                          ICIF_en;
    logic [31:0]                   ICIF_inst;
    logic                          RoB_clear;
    logic                          ICMC_en;
    logic [ADDR_WIDTH-1:0]         ICMC_addr;
    logic                          MCIC_en;
    logic [(32<<BLOCK_WIDTH)-1:0]  MCIC_block;

    modport slave (
        input  IFIC_en, IFIC_addr, RoB_clear, MCIC_en, MCIC_block,
        output ICIF_en, ICIF_inst, ICMC_en, ICMC_addr
    );

    modport master (
        output IFIC_en, IFIC_addr, RoB_clear, MCIC_en, MCIC_block,
        input  ICIF_en, ICIF_inst, ICMC_en, ICMC_addr
    );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped instruction cache between fetch unit and memory
// controller. One 32-bit instruction per fetch; a miss issues a block read,
// fills the line and delivers the requested word.
//
// Ports:
//   Sys_clk  - clock, rising edge
//   Sys_rst  - synchronous active-high reset (clears valid bits and outputs)
//   Sys_rdy  - global enable; when low all state holds
//   bus      - icache_if.slave: IFIC_*/ICIF_* fetch handshake, RoB_clear
//              flush, ICMC_*/MCIC_* block-read handshake
//
// Optional feature: ICACHE_FILL_FORWARD_EN - when defined the missed word is
// forwarded from MCIC_block in the fill cycle; otherwise the held request
// re-hits one cycle after the fill.
module icache #(
    parameter int BLOCK_WIDTH = 1,
    parameter int CACHE_WIDTH = 8,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic    Sys_clk,
    input  logic    Sys_rst,
    input  logic    Sys_rdy,
    icache_if.slave bus
);
    localparam int IDX_LSB   = BLOCK_WIDTH + 2;
    localparam int TAG_LSB   = CACHE_WIDTH + BLOCK_WIDTH + 2;
    localparam int TAG_WIDTH = ADDR_WIDTH - TAG_LSB;
    localparam int LINES     = 1 << CACHE_WIDTH;
    localparam int BLK_BITS  = 32 << BLOCK_WIDTH;

    typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]     valid_q;
    logic [TAG_WIDTH-1:0] tag_mem  [LINES];
    logic [BLK_BITS-1:0]  data_mem [LINES];

    logic                  icmc_en_q,   icmc_en_d;
    logic [ADDR_WIDTH-1:0] icmc_addr_q, icmc_addr_d;
    logic                  icif_en_q,   icif_en_d;
    logic [31:0]           icif_inst_q, icif_inst_d;
    logic                  fill_we;

    // Request address split
    logic [BLOCK_WIDTH-1:0] req_off;
    logic [CACHE_WIDTH-1:0] req_idx;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic                   req_hit;
    logic [BLK_BITS-1:0]    req_line;
    logic [31:0]            hit_word;

    assign req_off  = bus.IFIC_addr[IDX_LSB-1:2];
    assign req_idx  = bus.IFIC_addr[TAG_LSB-1:IDX_LSB];
    assign req_tag  = bus.IFIC_addr[ADDR_WIDTH-1:TAG_LSB];
    assign req_line = data_mem[req_idx];
    assign req_hit  = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign hit_word = req_line[{req_off, 5'd0} +: 32];

    // The outstanding block address doubles as the fill index/tag source
    logic [CACHE_WIDTH-1:0] fill_idx;
    logic [TAG_WIDTH-1:0]   fill_tag;

    assign fill_idx = icmc_addr_q[TAG_LSB-1:IDX_LSB];
    assign fill_tag = icmc_addr_q[ADDR_WIDTH-1:TAG_LSB];

    // Byte-lane bits of the PC carry no information
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.IFIC_addr[1:0];

`ifdef ICACHE_FILL_FORWARD_EN
    logic [BLOCK_WIDTH-1:0] off_q, off_d;
    logic [31:0]            fwd_word;

    assign fwd_word = bus.MCIC_block[{off_q, 5'd0} +: 32];
`endif

    always_comb begin
        state_d     = state_q;
        icmc_en_d   = icmc_en_q;
        icmc_addr_d = icmc_addr_q;
        icif_en_d   = 1'b0;
        icif_inst_d = icif_inst_q;
        fill_we     = 1'b0;
`ifdef ICACHE_FILL_FORWARD_EN
        off_d       = off_q;
`endif
        case (state_q)
            IDLE: begin
                // ICIF_en blocks acceptance so the still-held request of the
                // fetch just answered is not accepted twice
                if (bus.IFIC_en && !icif_en_q && !bus.RoB_clear) begin
                    if (req_hit) begin
                        icif_en_d   = 1'b1;
                        icif_inst_d = hit_word;
                    end else begin
                        state_d                  = FETCH;
                        icmc_en_d                = 1'b1;
                        icmc_addr_d              = bus.IFIC_addr;
                        icmc_addr_d[IDX_LSB-1:0] = '0;
`ifdef ICACHE_FILL_FORWARD_EN
                        off_d                    = req_off;
`endif
                    end
                end
            end
            FETCH: begin
                if (bus.MCIC_en) begin
                    fill_we   = 1'b1;
                    icmc_en_d = 1'b0;
                    state_d   = IDLE;
`ifdef ICACHE_FILL_FORWARD_EN
                    if (!bus.RoB_clear) begin
                        icif_en_d   = 1'b1;
                        icif_inst_d = fwd_word;
                    end
`endif
                end else if (bus.RoB_clear) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                // Memory read cannot be aborted; fill silently
                if (bus.MCIC_en) begin
                    fill_we   = 1'b1;
                    icmc_en_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Sys_clk) begin
        if (Sys_rst) begin
            state_q <= IDLE;
        end else if (Sys_rdy) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Sys_clk) begin
        if (Sys_rst) begin
            valid_q     <= '0;
            icmc_en_q   <= 1'b0;
            icmc_addr_q <= '0;
            icif_en_q   <= 1'b0;
            icif_inst_q <= '0;
        end else if (Sys_rdy) begin
            icmc_en_q   <= icmc_en_d;
            icmc_addr_q <= icmc_addr_d;
            icif_en_q   <= icif_en_d;
            icif_inst_q <= icif_inst_d;
            if (fill_we) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays are not reset; valid bits guard them
    always_ff @(posedge Sys_clk) begin
        if (Sys_rdy && fill_we && !Sys_rst) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= bus.MCIC_block;
        end
    end

`ifdef ICACHE_FILL_FORWARD_EN
    always_ff @(posedge Sys_clk) begin
        if (Sys_rst) begin
            off_q <= '0;
        end else if (Sys_rdy) begin
            off_q <= off_d;
        end
    end
`endif

    assign bus.ICMC_en   = icmc_en_q;
    assign bus.ICMC_addr = icmc_addr_q;
    assign bus.ICIF_en   = icif_en_q;
    assign bus.ICIF_inst = icif_inst_q;

endmodule

// File: tb/tb_icache.sv
// tb_icache: scoreboard bench for icache. Drivers push expected responses
// (instruction, hit/miss, issue cycle) and expected block reads; monitors pop
// and compare when ICIF_en / ICMC_en appear. A tb-side memory answers block
// reads and a line map (index -> resident block address) predicts hits.
module tb_icache;
    localparam int BW = 1;
    localparam int CW = 8;
    localparam int AW = 32;
`ifdef ICACHE_FILL_FORWARD_EN
    localparam int unsigned MISS_LAT = 1;
`else
    localparam int unsigned MISS_LAT = 2;
`endif

    logic Sys_clk = 1'b0;
    logic Sys_rst;
    logic Sys_rdy;

    icache_if #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) bus ();

    icache #(.BLOCK_WIDTH(BW), .CACHE_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
        .Sys_clk (Sys_clk),
        .Sys_rst (Sys_rst),
        .Sys_rdy (Sys_rdy),
        .bus     (bus)
    );

    always #5 Sys_clk = ~Sys_clk;

    int unsigned cyc = 0;
    always @(posedge Sys_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] inst;
        bit          hit;
        int unsigned issue;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned rise;
    } req_t;

    resp_t       sb_q[$];
    req_t        mc_q[$];
    logic [31:0] fill_q[$];
    logic [31:0] line_blk [int unsigned];

    int unsigned last_mc_cyc = 0;
    int unsigned icif_seen   = 0;
    int unsigned dly_min     = 0;
    int unsigned dly_max     = 3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory contents: test-plan block at 0x1000, a hash elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'h1111_1111;
        if (a == 32'h0000_1004) return 32'h2222_2222;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a >> (BW + 2)) % (1 << CW);
    endfunction

    function automatic logic [31:0] blk_of(input logic [31:0] a);
        return (a >> (BW + 2)) << (BW + 2);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int unsigned i = idx_of(a);
        return line_blk.exists(i) && (line_blk[i] == blk_of(a));
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] tag, idx, off;
        tag = 32'($urandom_range(0, 3));
        if (tag == 3) tag = 32'h001F_FFFF;
        idx = 32'($urandom_range(0, 3));
        off = 32'($urandom_range(0, (1 << BW) - 1));
        return (tag << (CW + BW + 2)) | (idx << (BW + 2)) | (off << 2);
    endfunction

    // Memory controller: answers a held ICMC_en after a random delay
    initial begin
        bit          armed = 0;
        int unsigned cnt   = 0;
        logic [(32<<BW)-1:0] blk;
        logic [31:0] fa;
        bus.MCIC_en    = 1'b0;
        bus.MCIC_block = '0;
        forever begin
            @(posedge Sys_clk);
            #1;
            if (bus.MCIC_en) begin
                bus.MCIC_en = 1'b0;
                check("icmc_drop_after_mcic", 32'(bus.ICMC_en), 32'd0);
            end else if (bus.ICMC_en && Sys_rdy) begin
                if (!armed) begin
                    armed = 1;
                    cnt   = $urandom_range(dly_max, dly_min);
                end
                if (cnt == 0) begin
                    for (int k = 0; k < (1 << BW); k++)
                        blk[32*k +: 32] = mem_word(bus.ICMC_addr + 32'(4 * k));
                    bus.MCIC_block = blk;
                    bus.MCIC_en    = 1'b1;
                    armed          = 0;
                    last_mc_cyc    = cyc;
                    if (fill_q.size() != 0) begin
                        fa = fill_q.pop_front();
                        line_blk[idx_of(fa)] = blk_of(fa);
                    end
                end else begin
                    cnt--;
                end
            end else if (!bus.ICMC_en) begin
                armed = 0;
            end
        end
    end

    // Monitor: compares DUT outputs against queued expectations
    initial begin
        logic        prev_icif = 1'b0;
        logic        prev_icmc = 1'b0;
        logic [31:0] held_addr = '0;
        resp_t       r;
        req_t        q;
        forever begin
            @(negedge Sys_clk);
            if (bus.ICIF_en) begin
                icif_seen++;
                check("icif_single_pulse", 32'(prev_icif), 32'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL icif_unexpected: got inst 0x%08h expected no response (cycle %0d)",
                             bus.ICIF_inst, cyc);
                end else begin
                    r = sb_q.pop_front();
                    check("icif_inst", bus.ICIF_inst, r.inst);
                    check(r.hit ? "hit_latency" : "miss_latency", cyc,
                          r.hit ? r.issue + 1 : last_mc_cyc + MISS_LAT);
                end
            end
            if (bus.ICMC_en && !prev_icmc) begin
                held_addr = bus.ICMC_addr;
                if (mc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL icmc_unexpected: got addr 0x%08h expected no block read (cycle %0d)",
                             bus.ICMC_addr, cyc);
                end else begin
                    q = mc_q.pop_front();
                    check("icmc_addr", bus.ICMC_addr, q.addr);
                    check("icmc_rise_cycle", cyc, q.rise);
                end
            end else if (bus.ICMC_en) begin
                check("icmc_addr_stable", bus.ICMC_addr, held_addr);
            end
            prev_icif = bus.ICIF_en;
            prev_icmc = bus.ICMC_en;
        end
    end

    task automatic step();
        @(posedge Sys_clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a);
        resp_t r;
        req_t  q;
        r.inst  = mem_word(a);
        r.hit   = model_hit(a);
        r.issue = cyc;
        sb_q.push_back(r);
        if (!r.hit) begin
            q.addr = blk_of(a);
            q.rise = cyc + 1;
            mc_q.push_back(q);
            fill_q.push_back(a);
        end
        bus.IFIC_en   = 1'b1;
        bus.IFIC_addr = a;
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.ICIF_en) begin
                bus.IFIC_en = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL resp_timeout: got no ICIF_en expected one within 200 cycles (cycle %0d)", cyc);
        bus.IFIC_en = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        step();
        issue(a);
        wait_resp();
    endtask

    initial begin
        int unsigned seen0;
        logic [31:0] snap_inst;

        Sys_rst       = 1'b1;
        Sys_rdy       = 1'b1;
        bus.IFIC_en   = 1'b0;
        bus.IFIC_addr = '0;
        bus.RoB_clear = 1'b0;
        repeat (3) step();
        Sys_rst = 1'b0;
        check("rst_icif_en",   32'(bus.ICIF_en), 32'd0);
        check("rst_icif_inst", bus.ICIF_inst,    32'd0);
        check("rst_icmc_en",   32'(bus.ICMC_en), 32'd0);
        check("rst_icmc_addr", bus.ICMC_addr,    32'd0);

        // Cold miss, hit, conflict miss, conflict refetch
        dly_min = 2; dly_max = 2;
        fetch(32'h0000_1004);
        fetch(32'h0000_1000);
        fetch(32'h0000_1800);
        fetch(32'h0000_1000);

        // Flush two cycles into a miss: line filled, no response
        dly_min = 6; dly_max = 6;
        step();
        issue(32'h0000_2008);
        step();
        step();
        bus.RoB_clear = 1'b1;
        bus.IFIC_en   = 1'b0;
        void'(sb_q.pop_back());
        seen0 = icif_seen;
        step();
        bus.RoB_clear = 1'b0;
        for (int i = 0; i < 50 && bus.ICMC_en; i++) step();
        repeat (3) step();
        check("flush_no_resp", icif_seen, seen0);
        check("flush_icmc_released", 32'(bus.ICMC_en), 32'd0);
        fetch(32'h0000_200C);

        // Reset during FETCH: request dropped, all lines invalidated
        dly_min = 20; dly_max = 20;
        step();
        issue(32'h0000_3010);
        step();
        step();
        Sys_rst     = 1'b1;
        bus.IFIC_en = 1'b0;
        step();
        Sys_rst = 1'b0;
        check("rst_fetch_icmc_en", 32'(bus.ICMC_en), 32'd0);
        check("rst_fetch_icif_en", 32'(bus.ICIF_en), 32'd0);
        sb_q.delete();
        mc_q.delete();
        fill_q.delete();
        line_blk.delete();
        dly_min = 1; dly_max = 1;
        fetch(32'h0000_1000);

        // Sys_rdy low for 5 cycles during FETCH
        dly_min = 12; dly_max = 12;
        step();
        issue(32'h0000_4004);
        step();
        step();
        snap_inst = bus.ICIF_inst;
        Sys_rdy   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rdy_hold_icmc_en",   32'(bus.ICMC_en), 32'd1);
            check("rdy_hold_icmc_addr", bus.ICMC_addr,    32'h0000_4000);
            check("rdy_hold_icif_en",   32'(bus.ICIF_en), 32'd0);
            check("rdy_hold_icif_inst", bus.ICIF_inst,    snap_inst);
        end
        Sys_rdy = 1'b1;
        wait_resp();

        // Randomized traffic over a few indices and conflicting tags
        dly_min = 0; dly_max = 3;
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) step();
            fetch(rand_addr());
        end

        repeat (5) step();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("mc_drained", 32'(mc_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the instruction-fetch unit and the memory controller. It returns one 32-bit instruction per fetch request. On a miss it initiates a block read on the memory controller's ICache port, fills the line, and forwards the requested word. It is the initiator side of the `ICMC_*`/`MCIC_*` handshake and the only client of that port.

## Interface
- `BLOCK_WIDTH`, default 1: a block holds 2^BLOCK_WIDTH instructions (64 bits at default).
- `CACHE_WIDTH`, default 8: 2^CACHE_WIDTH lines.
- `ADDR_WIDTH`, default 32: byte address width.
- Derived: tag width = ADDR_WIDTH − CACHE_WIDTH − BLOCK_WIDTH − 2 (21 at defaults).
- `Sys_clk` in, 1: the single clock. Everything is on the rising edge.
- `Sys_rst` in, 1: synchronous, active-high reset.
- `Sys_rdy` in, 1: when low, all state holds.
- `IFIC_en` in, 1: fetch request. Held high with `IFIC_addr` stable until `ICIF_en`.
- `IFIC_addr` in, ADDR_WIDTH: PC. Bits [1:0] are 0 and ignored.
- `ICIF_en` out, 1: one-cycle pulse; `ICIF_inst` is valid.
- `ICIF_inst` out, 32: fetched instruction.
- `RoB_clear` in, 1: pipeline flush. The pending fetch is dropped.
- `ICMC_en` out, 1: block-read request. Level, held until `MCIC_en`.
- `ICMC_addr` out, ADDR_WIDTH: block-aligned address; low BLOCK_WIDTH+2 bits are 0.
- `MCIC_en` in, 1: one-cycle pulse; `MCIC_block` is valid.
- `MCIC_block` in, 32·2^BLOCK_WIDTH: bits [32k+31:32k] hold the word at block base + 4k.

## Operation
- Address split: offset = addr[BLOCK_WIDTH+1:2], index = addr[CACHE_WIDTH+BLOCK_WIDTH+1:BLOCK_WIDTH+2], tag = upper bits.
- Storage: per line, one valid bit, one tag and one data block. Valid bits clear on reset; data and tags are not reset.
- States: IDLE, FETCH, DROP.
- **IDLE: request acceptance.**
  - A request is accepted when `IFIC_en`=1, `ICIF_en`=0 and `RoB_clear`=0.
  - Hit (valid and tag match): next cycle `ICIF_en`=1, `ICIF_inst` = word[offset].
  - Miss: go to FETCH. `ICMC_en`<=1. `ICMC_addr`<= `IFIC_addr` with the low BLOCK_WIDTH+2 bits zeroed. The offset is latched.
- **FETCH: waiting on the memory controller.**
  - Wait for `MCIC_en`. On it, write the block, tag and valid bit, and set `ICMC_en`<=0 (low in the very next cycle).
  - Then deliver the requested word (see Configuration) and return to IDLE.
- **DROP: fill after a flush.**
  - Entered from FETCH when `RoB_clear`=1.
  - The memory transaction cannot be aborted, so `ICMC_en` stays high until `MCIC_en`.
  - The line is still filled. No `ICIF_en` is produced. Return to IDLE.
- **`RoB_clear` priority.**
  - `RoB_clear` in IDLE suppresses acceptance and forces `ICIF_en`<=0.
  - `RoB_clear` in the same cycle as `MCIC_en` (FETCH): fill the line, no response.
- Reset mid-FETCH: state <= IDLE, `ICMC_en`<=0, all valid bits <=0. The memory controller resets in the same domain.
- Output reset values: `ICMC_en`=0, `ICMC_addr`=0, `ICIF_en`=0, `ICIF_inst`=0.

## Timing
- Hit: request accepted at edge N, so `ICIF_en` is high for exactly cycle N+1. Next acceptance is possible at edge N+2, giving a throughput of one hit per 2 cycles.
- Miss: `ICMC_en` rises in cycle N+1. `ICMC_en` and `ICMC_addr` are stable until the edge that samples `MCIC_en`=1.
- `ICMC_en` must be 0 in the cycle after `MCIC_en`. The memory controller re-arms on `ICMC_en && !MCIC_en`, so any later deassertion causes a spurious refetch.
- `ICIF_en` is never high for 2 consecutive cycles.

## Configuration
- `ICACHE_FILL_FORWARD_EN` defined:
  - On the edge sampling `MCIC_en`, `ICIF_inst` <= `MCIC_block` word[latched offset] and `ICIF_en`<=1.
  - Miss response appears the cycle after `MCIC_en`.
- Undefined:
  - FETCH returns to IDLE after the fill. The still-held request re-hits.
  - `ICIF_en` appears 2 cycles after `MCIC_en`.
- Functional results are identical in both builds; only miss latency differs.

## Test plan
- Cold miss, 0x00001004: `ICMC_addr`=0x00001000. Model returns block 0x22222222_11111111, then `ICIF_inst`=0x22222222. Timing: 1 cycle after `MCIC_en` with the macro, 2 cycles without it.
- Then fetch 0x00001000: hit. No `ICMC_en`; `ICIF_inst`=0x11111111 one cycle after acceptance.
- Conflict 0x00001800 (same index, different tag): miss, refill. A refetch of 0x00001000 then misses again.
- `RoB_clear` pulse two cycles after a miss starts: `ICMC_en` held until `MCIC_en`, no `ICIF_en`. A subsequent fetch of the same block hits.
- `Sys_rst` during FETCH: `ICMC_en`=0 next cycle. The previously filled 0x00001000 now misses.
- `Sys_rdy`=0 for 5 cycles during FETCH with `MCIC_en` low: all outputs hold. Confirm `ICMC_en` drops exactly one cycle after `MCIC_en`.
